// File: rtl/mem_preload_pkg.sv
// Shared types and default configuration for the boot-time SRAM preload controller.
package mem_preload_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE,
    ERR
  } state_t;

  localparam int DFLT_DATA_W       = 64;
  localparam int DFLT_BANK_SEL_LSB = 26;
  localparam int DFLT_NUM_BANKS    = 4;

  // Up to 32 banks; callers cast the result down to their bank count.
  function automatic logic [31:0] onehot_bank(input logic [4:0] sel);
    return 32'd1 << sel;
  endfunction

endpackage

// File: rtl/mem_preload_wr_stage.sv
// Single-entry SRAM write output register: holds a strobe stable until the bank
// accepts it and can be refilled in the same cycle the previous write retires.
module mem_preload_wr_stage
  import mem_preload_pkg::*;
#(
  parameter int DATA_W       = DFLT_DATA_W,
  parameter int BANK_SEL_LSB = DFLT_BANK_SEL_LSB,
  parameter int NUM_BANKS    = DFLT_NUM_BANKS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [NUM_BANKS-1:0]    load_en,
  input  logic [BANK_SEL_LSB-1:0] load_addr,
  input  logic [DATA_W-1:0]       load_data,
  input  logic                    mem_ready,
  output logic                    can_load,
  output logic                    wr_done,
  output logic [NUM_BANKS-1:0]    mem_en,
  output logic [DATA_W/8-1:0]     mem_be,
  output logic [BANK_SEL_LSB-1:0] mem_addr,
  output logic [DATA_W-1:0]       mem_wdata
);

  logic pending;

  assign wr_done  = pending & mem_ready;
  assign can_load = ~pending | mem_ready;

  // p0: strobe/control register, dropped asynchronously on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      mem_en  <= '0;
      mem_be  <= '0;
    end else if (load) begin
      pending <= 1'b1;
      mem_en  <= load_en;
      mem_be  <= '1;
    end else if (wr_done) begin
      pending <= 1'b0;
      mem_en  <= '0;
      mem_be  <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (load) begin
      mem_addr  <= load_addr;
      mem_wdata <= load_data;
    end
  end

endmodule

// File: rtl/mem_preload_ctrl.sv
// Front-door image loader: streams words into the banked SRAM and holds the
// core in reset until the whole image has been written.
module mem_preload_ctrl
  import mem_preload_pkg::*;
#(
  parameter int DATA_W       = DFLT_DATA_W,
  parameter int BANK_SEL_LSB = DFLT_BANK_SEL_LSB,
  parameter int NUM_BANKS    = DFLT_NUM_BANKS,
  parameter int ADDR_W       = BANK_SEL_LSB + $clog2(NUM_BANKS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [ADDR_W-1:0]       start_base,
  input  logic [ADDR_W:0]         start_count,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic [NUM_BANKS-1:0]    mem_en,
  output logic [DATA_W/8-1:0]     mem_be,
  output logic [BANK_SEL_LSB-1:0] mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_ready,
  output logic                    core_reset,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_W:0]         words_written
);

  localparam logic [ADDR_W+1:0] LIMIT = (ADDR_W+2)'(NUM_BANKS) << BANK_SEL_LSB;

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      addr;
  logic [ADDR_W:0]        remaining;
  logic [ADDR_W+1:0]      cmd_end;
  logic [NUM_BANKS-1:0]   bank_en;
  logic                   cmd_acc, beat_acc, can_load, wr_done;

  assign start_ready = (state == IDLE) || (state == DONE) || (state == ERR);
  assign busy        = (state == LOAD) || (state == FLUSH);
  assign in_ready    = (state == LOAD) && can_load;
  assign cmd_acc     = start_valid && start_ready;
  assign beat_acc    = in_valid && in_ready;
  assign cmd_end     = {2'b00, start_base} + {1'b0, start_count};
  assign bank_en     = NUM_BANKS'(onehot_bank(5'(addr[ADDR_W-1:BANK_SEL_LSB])));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (cmd_acc) begin
          if (cmd_end > LIMIT)       state_nxt = ERR;
          else if (start_count == '0) state_nxt = DONE;
          else                        state_nxt = LOAD;
        end
      end
      LOAD:    if (beat_acc && (remaining == (ADDR_W+1)'(1))) state_nxt = FLUSH;
      FLUSH:   if (wr_done) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track it glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      core_reset    <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      state      <= state_nxt;
      core_reset <= (state_nxt != DONE);
      done       <= (state_nxt == DONE);
      err        <= (state_nxt == ERR);
      if (cmd_acc)      words_written <= '0;
      else if (wr_done) words_written <= words_written + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (cmd_acc) begin
      addr      <= start_base;
      remaining <= start_count;
    end else if (beat_acc) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - (ADDR_W+1)'(1);
    end
  end

  mem_preload_wr_stage #(
    .DATA_W       (DATA_W),
    .BANK_SEL_LSB (BANK_SEL_LSB),
    .NUM_BANKS    (NUM_BANKS)
  ) u_wr_stage (
    .clock     (clock),
    .reset     (reset),
    .load      (beat_acc),
    .load_en   (bank_en),
    .load_addr (addr[BANK_SEL_LSB-1:0]),
    .load_data (in_data),
    .mem_ready (mem_ready),
    .can_load  (can_load),
    .wr_done   (wr_done),
    .mem_en    (mem_en),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_mem_preload_ctrl.sv
// Randomized bench for mem_preload_ctrl against an address/data list model.
module tb_mem_preload_ctrl;

  localparam int DATA_W = 64;
  localparam int BSL    = 26;
  localparam int NB     = 4;
  localparam int AW     = 28;

  logic              clock = 1'b0;
  logic              reset;
  logic              start_valid, start_ready;
  logic [AW-1:0]     start_base;
  logic [AW:0]       start_count;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic [NB-1:0]     mem_en;
  logic [7:0]        mem_be;
  logic [BSL-1:0]    mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready, core_reset, busy, done, err;
  logic [AW:0]       words_written;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_preload_ctrl dut (
    .clock(clock), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_base(start_base), .start_count(start_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .core_reset(core_reset), .busy(busy),
    .done(done), .err(err), .words_written(words_written)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a command; returns at the falling edge after the accepting edge.
  task automatic send_cmd(input logic [AW-1:0] base, input logic [AW:0] cnt);
    @(negedge clock);
    start_valid = 1'b1;
    start_base  = base;
    start_count = cnt;
    #1;
    chk("start_ready", 64'(start_ready), 64'd1);
    @(negedge clock);
    start_valid = 1'b0;
  endtask

  // mode 0: ready always high, sequential data; 1: random valid/ready; 2: 3-cycle stall on 2nd write
  task automatic run_load(input logic [AW-1:0] base, input int n, input int mode);
    logic [DATA_W-1:0] words[$];
    logic [AW:0]       idx;
    logic [NB-1:0]     p_en;
    logic [BSL-1:0]    p_addr;
    logic [DATA_W-1:0] p_data;
    logic              prev_hold;
    int sent, seen, cyc, first, last, stall;
    sent = 0; seen = 0; cyc = 0; first = -1; last = 0; stall = 0; prev_hold = 1'b0;
    p_en = '0; p_addr = '0; p_data = '0;
    for (int i = 0; i < n; i++)
      words.push_back(mode == 0 ? 64'h11 * 64'(i + 1) : {$urandom(), $urandom()});
    send_cmd(base, (AW+1)'(n));
    chk("core_reset_load", 64'(core_reset), 64'd1);
    chk("busy_load", 64'(busy), 64'd1);
    chk("done_clr", 64'(done), 64'd0);
    chk("err_clr", 64'(err), 64'd0);
    while (seen < n && cyc < 2000) begin
      in_valid = (sent < n) && (mode != 1 || $urandom_range(0, 3) != 0);
      in_data  = (sent < n) ? words[sent] : {$urandom(), $urandom()};
      if (mode == 1) mem_ready = ($urandom_range(0, 2) != 0);
      else if (mode == 2 && seen == 1 && mem_en != '0 && stall < 3) begin
        mem_ready = 1'b0;
        stall++;
      end else mem_ready = 1'b1;
      #1;
      chk("words_written", 64'(words_written), 64'(seen));
      chk("pending", 64'(mem_en != '0), 64'(sent > seen));
      chk("in_ready", 64'(in_ready), 64'((sent < n) && (mem_en == '0 || mem_ready)));
      if (prev_hold) begin
        chk("hold_en", 64'(mem_en), 64'(p_en));
        chk("hold_addr", 64'(mem_addr), 64'(p_addr));
        chk("hold_data", mem_wdata, p_data);
      end
      if (mem_en != '0) chk("mem_be", 64'(mem_be), 64'hFF);
      if (mem_en != '0 && mem_ready) begin
        idx = {1'b0, base} + (AW+1)'(seen);
        chk("mem_en", 64'(mem_en), 64'(NB'(1) << idx[AW-1:BSL]));
        chk("mem_addr", 64'(mem_addr), 64'(idx[BSL-1:0]));
        chk("mem_wdata", mem_wdata, words[seen]);
        if (first < 0) first = cyc;
        last = cyc;
        seen++;
      end
      prev_hold = (mem_en != '0) && !mem_ready;
      p_en = mem_en; p_addr = mem_addr; p_data = mem_wdata;
      if (in_valid && in_ready) sent++;
      cyc++;
      @(negedge clock);
    end
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("timeout", 64'(cyc < 2000), 64'd1);
    chk("done_end", 64'(done), 64'd1);
    chk("core_reset_end", 64'(core_reset), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    chk("words_end", 64'(words_written), 64'(n));
    chk("mem_en_end", 64'(mem_en), 64'd0);
    if (mode == 0) chk("throughput", 64'(last - first), 64'(n - 1));
  endtask

  initial begin
    logic [AW-1:0] b;
    int n, seen, cyc;
    reset = 1'b0; start_valid = 1'b0; start_base = '0; start_count = '0;
    in_valid = 1'b0; in_data = '0; mem_ready = 1'b0;
    #2 reset = 1'b1;
    #2;
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_be", 64'(mem_be), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_status", 64'({busy, done, err}), 64'd0);
    chk("rst_words", 64'(words_written), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    run_load(28'h0, 4, 0);
    run_load(28'h3FFFFFE, 4, 0);
    run_load(28'h100, 5, 2);

    // out-of-range command, then recovery
    in_valid = 1'b1;
    send_cmd(28'hFFFFFFF, (AW+1)'(2));
    #1;
    chk("err_set", 64'(err), 64'd1);
    chk("err_core_reset", 64'(core_reset), 64'd1);
    chk("err_done", 64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("err_mem_en", 64'(mem_en), 64'd0);
      chk("err_in_ready", 64'(in_ready), 64'd0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    run_load(28'h0, 1, 0);

    // zero-length command with in_valid held high
    in_valid = 1'b1;
    send_cmd(28'h12345, '0);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_core_reset", 64'(core_reset), 64'd0);
      chk("zero_mem_en", 64'(mem_en), 64'd0);
      chk("zero_in_ready", 64'(in_ready), 64'd0);
      chk("zero_words", 64'(words_written), 64'd0);
      @(negedge clock);
      #1;
    end
    in_valid = 1'b0;

    // randomized loads, some straddling bank boundaries
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 20);
      if (k % 2 == 0) b = AW'($urandom_range(1, 3)) << BSL;
      else            b = AW'($urandom_range(0, 28'hFFFFF00));
      if (k % 2 == 0) b = b - AW'($urandom_range(1, 12));
      run_load(b, n, 1);
    end

    // reset mid-load after 2 of 8 words
    send_cmd(28'h2000, (AW+1)'(8));
    in_valid = 1'b1; mem_ready = 1'b1; seen = 0; cyc = 0;
    while (seen < 2 && cyc < 20) begin
      in_data = {$urandom(), $urandom()};
      #1;
      if (mem_en != '0 && mem_ready) seen++;
      cyc++;
      @(negedge clock);
    end
    chk("rst_pre_pending", 64'(mem_en != '0), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_mem_en", 64'(mem_en), 64'd0);
    chk("abort_core_reset", 64'(core_reset), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    #1;
    chk("post_words", 64'(words_written), 64'd0);
    chk("post_start_ready", 64'(start_ready), 64'd1);
    chk("post_status", 64'({busy, done, err}), 64'd0);
    chk("post_mem_en", 64'(mem_en), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
